oct_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters.
- Produces a one-hot grant and its 3-bit binary index; the index uses the same encoding as the team's 8-to-3 octal-to-binary encoder (bit0 -> 000 ... bit7 -> 111).
- Sits in front of the shared datapath. The downstream mux selects on gnt_idx; requesters watch their own gnt bit.
- A per-owner hold limit stops one requester from starving the others.

---
 rtl/oct_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_oct_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oct_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index and per-owner hold limit.
// Optional build macro OCT_ARB_LOCK_EN adds a `lock` input that suspends the hold limit while the owner keeps requesting.
module oct_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef OCT_ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  // First set bit of vec, scanning start, start+1, ... with wrap from 7 to 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] pos;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      pos = start + 3'(k);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  logic [2:0] owner;
  logic [2:0] owner_next;
  logic       owner_req;
  logic [7:0] others;
  logic       other_any;
  logic       at_limit;
  logic       lock_active;
  logic [3:0] pick_idle;
  logic [3:0] pick_rot;

  always_comb begin
    owner      = gnt_idx;
    owner_next = gnt_idx + 3'd1;
    owner_req  = req[gnt_idx];
    others     = req & ~onehot(gnt_idx);
    other_any  = |others;
    at_limit   = (hold_cnt >= HOLD_LAST);
    pick_idle  = rr_pick(req, ptr);
    // Both release and preempt search the non-owner requests from owner+1.
    pick_rot   = rr_pick(others, owner_next);
`ifdef OCT_ARB_LOCK_EN
    lock_active = lock;
`else
    lock_active = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_idle[3]) begin
            state     <= S_GRANT;
            gnt       <= onehot(pick_idle[2:0]);
            gnt_idx   <= pick_idle[2:0];
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end

        S_GRANT: begin
          if (!owner_req) begin
            ptr <= owner_next;
            if (pick_rot[3]) begin
              gnt      <= onehot(pick_rot[2:0]);
              gnt_idx  <= pick_rot[2:0];
              hold_cnt <= '0;
            end else begin
              state     <= S_IDLE;
              gnt       <= 8'd0;
              gnt_idx   <= 3'd0;
              gnt_valid <= 1'b0;
              hold_cnt  <= '0;
            end
          end else if (lock_active) begin
            hold_cnt <= hold_cnt;
          end else if (!at_limit || !other_any) begin
            if (!at_limit) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            ptr      <= owner_next;
            gnt      <= onehot(pick_rot[2:0]);
            gnt_idx  <= pick_rot[2:0];
            hold_cnt <= '0;
          end
        end

        default: begin
          state     <= S_IDLE;
          gnt       <= 8'd0;
          gnt_idx   <= 3'd0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  // owner is the same value as gnt_idx; kept as a name for readability in the FSM.
  logic unused_owner;
  assign unused_owner = ^owner;

endmodule

// File: tb/tb_oct_rr_arbiter.sv
// Directed bench for oct_rr_arbiter: one instance per hold limit under test, shared req/reset.
module tb_oct_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt_h4, gnt_h1;
  logic [2:0] idx_h4, idx_h1;
  logic       vld_h4, vld_h1;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  oct_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst_n(rst_n),
`ifdef OCT_ARB_LOCK_EN
    .lock(1'b0),
`endif
    .req(req), .gnt(gnt_h4), .gnt_idx(idx_h4), .gnt_valid(vld_h4)
  );

  oct_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst_n(rst_n),
`ifdef OCT_ARB_LOCK_EN
    .lock(1'b0),
`endif
    .req(req), .gnt(gnt_h1), .gnt_idx(idx_h1), .gnt_valid(vld_h1)
  );

`ifdef OCT_ARB_LOCK_EN
  logic       lock;
  logic [7:0] gnt_h2;
  logic [2:0] idx_h2;
  logic       vld_h2;

  oct_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_h2 (
    .clk(clk), .rst_n(rst_n), .lock(lock),
    .req(req), .gnt(gnt_h2), .gnt_idx(idx_h2), .gnt_valid(vld_h2)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'd0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt_h4 !== 8'd0 || idx_h4 !== 3'd0 || vld_h4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b idx=%0d valid=%b, want 0/0/0", gnt_h4, idx_h4, vld_h4);
    end
    req = 8'b0000_0100;
    step();
    n_checks++;
    if (gnt_h4 !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL single_gnt: got %b want 00000100", gnt_h4);
    end
    n_checks++;
    if (idx_h4 !== 3'b010 || vld_h4 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idx: idx=%b valid=%b want 010/1", idx_h4, vld_h4);
    end
    // Reset in the middle of a cycle, well away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_h4 !== 8'd0 || idx_h4 !== 3'd0 || vld_h4 !== 1'b0 ||
        gnt_h1 !== 8'd0 || vld_h1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: gnt=%b idx=%0d valid=%b (h1 gnt=%b valid=%b), want all 0",
               gnt_h4, idx_h4, vld_h4, gnt_h1, vld_h1);
    end
    step();
    rst_n = 1'b1;
    req   = 8'd0;
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    do_reset();
    req = 8'b1000_0001;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_idx = (i % 2 == 0) ? 3'd0 : 3'd7;
      n_checks++;
      if (idx_h1 !== exp_idx || vld_h1 !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation[%0d]: idx=%0d valid=%b want %0d/1", i, idx_h1, vld_h1, exp_idx);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b0100_0000;
    step();
    n_checks++;
    if (idx_h4 !== 3'd6) begin
      n_fail++;
      $display("FAIL wrap_first: idx=%0d want 6", idx_h4);
    end
    req = 8'b0010_0001;
    step();
    n_checks++;
    if (idx_h4 !== 3'd0 || gnt_h4 !== 8'b0000_0001 || vld_h4 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_next: idx=%0d gnt=%b valid=%b want 0/00000001/1", idx_h4, gnt_h4, vld_h4);
    end
  endtask

  task automatic test_hold_limit();
    logic [2:0] exp_idx;
    do_reset();
    req = 8'b0000_0011;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_idx = ((i / 4) % 2 == 0) ? 3'd0 : 3'd1;
      n_checks++;
      if (idx_h4 !== exp_idx || gnt_h4 !== (8'b1 << exp_idx)) begin
        n_fail++;
        $display("FAIL hold_limit[%0d]: idx=%0d gnt=%b want idx %0d", i, idx_h4, gnt_h4, exp_idx);
      end
    end
    do_reset();
    req = 8'b0000_0001;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (idx_h4 !== 3'd0 || vld_h4 !== 1'b1 || idx_h1 !== 3'd0 || vld_h1 !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_alone[%0d]: h4 idx=%0d v=%b h1 idx=%0d v=%b want 0/1", i,
                 idx_h4, vld_h4, idx_h1, vld_h1);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'b0000_1000;
    step();
    req = 8'b0010_1000;
    step();
    n_checks++;
    if (idx_h4 !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_owner_kept: idx=%0d want 3", idx_h4);
    end
    req = 8'b0010_0000;
    step();
    n_checks++;
    if (gnt_h4 !== 8'b0010_0000 || vld_h4 !== 1'b1 || idx_h4 !== 3'd5) begin
      n_fail++;
      $display("FAIL b2b_release: gnt=%b idx=%0d valid=%b want 00100000/5/1", gnt_h4, idx_h4, vld_h4);
    end
    req = 8'd0;
    step();
    n_checks++;
    if (vld_h4 !== 1'b0 || gnt_h4 !== 8'd0 || idx_h4 !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_idle: gnt=%b idx=%0d valid=%b want 0/0/0", gnt_h4, idx_h4, vld_h4);
    end
  endtask

  task automatic test_invariants();
    logic [7:0] sampled;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) req = 8'($urandom_range(0, 255));
      sampled = req;
      step();
      n_checks++;
      if (!$onehot0(gnt_h4) || (vld_h4 !== (|gnt_h4)) ||
          (vld_h4 && gnt_h4 !== (8'b1 << idx_h4)) || (!vld_h4 && idx_h4 !== 3'd0) ||
          ((gnt_h4 & ~sampled) !== 8'd0)) begin
        n_fail++;
        $display("FAIL invariant_h4[%0d]: req=%b gnt=%b idx=%0d valid=%b", i, sampled, gnt_h4, idx_h4, vld_h4);
      end
      n_checks++;
      if (!$onehot0(gnt_h1) || (vld_h1 !== (|gnt_h1)) ||
          (vld_h1 && gnt_h1 !== (8'b1 << idx_h1)) || (!vld_h1 && idx_h1 !== 3'd0) ||
          ((gnt_h1 & ~sampled) !== 8'd0)) begin
        n_fail++;
        $display("FAIL invariant_h1[%0d]: req=%b gnt=%b idx=%0d valid=%b", i, sampled, gnt_h1, idx_h1, vld_h1);
      end
    end
    req = 8'd0;
  endtask

`ifdef OCT_ARB_LOCK_EN
  task automatic test_lock();
    lock = 1'b1;
    do_reset();
    req = 8'b0000_0011;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (idx_h2 !== 3'd0 || vld_h2 !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: idx=%0d valid=%b want 0/1", i, idx_h2, vld_h2);
      end
    end
    lock = 1'b0;
    step();
    step();
    n_checks++;
    if (idx_h2 !== 3'd1) begin
      n_fail++;
      $display("FAIL lock_release: idx=%0d want 1", idx_h2);
    end
    req = 8'd0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req   = 8'd0;
`ifdef OCT_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    test_reset();
    test_rotation();
    test_wrap();
    test_hold_limit();
    test_back_to_back();
    test_invariants();
`ifdef OCT_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
